// File: rtl/dvv_cap_fifo_pkg.sv
// Shared defaults and helpers for the multi-channel capture FIFO.
package dvv_hw_pkg;

  localparam int CH_N_DEF   = 4;
  localparam int DW_DEF     = 32;
  localparam int DEPTH_DEF  = 16;
  localparam int TSW_DEF    = 16;
  localparam int DROP_CNT_W = 16;

  // Index width that stays at least one bit for single-entry sets.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dvv_cap_fifo_rr_arb.sv
// Round-robin arbiter: one-hot grant among requesters, searching from the pointer.
module dvv_rr_arb
  import dvv_hw_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  logic [IW-1:0] idx;
  int            sum;
  int            nxt;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    sum       = 0;
    nxt       = 0;
    for (int i = 0; i < N; i++) begin
      sum = int'(ptr_q) + i;
      if (sum >= N) sum = sum - N;
      idx = IW'(sum);
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
    // Pointer moves just past the winner so it becomes lowest priority next.
    nxt = int'(gnt_idx_o) + 1;
    if (nxt >= N) nxt = 0;
    ptr_d = found ? IW'(nxt) : ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dvv_cap_fifo.sv
// Multi-channel timestamped capture: per-channel holding registers merged
// round-robin into one show-ahead FIFO with drop counting and overflow flags.
module dvv_cap_fifo
  import dvv_hw_pkg::*;
#(
  parameter  int CH_N  = CH_N_DEF,
  parameter  int DW    = DW_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int TSW   = TSW_DEF,
  localparam int CW    = clog2_min1(CH_N),
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [CH_N-1:0]       ch_vld_i,
  input  logic [CH_N*DW-1:0]    ch_data_i,
  output logic                  rd_vld_o,
  input  logic                  rd_rdy_i,
  output logic [DW-1:0]         rd_data_o,
  output logic [CW-1:0]         rd_ch_o,
  output logic [TSW-1:0]        rd_ts_o,
  output logic [LW-1:0]         level_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o,
  output logic [CH_N-1:0]       ovf_mask_o
);

  localparam int EW = CW + TSW + DW;

  logic [TSW-1:0]        ts_q, ts_d;
  logic [CH_N-1:0]       hold_vld;
  logic [CH_N*DW-1:0]    hold_data;
  logic [CH_N*TSW-1:0]   hold_ts;
  logic [CH_N-1:0]       cap, drop, gnt;
  logic [CW-1:0]         gnt_idx;
  logic                  push, pop, can_acc;

  logic [EW-1:0]         mem [DEPTH];
  logic [EW-1:0]         wr_entry, head;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;

  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_CNT_W:0]   drop_sum;
  logic [CH_N-1:0]       ovf_q, ovf_d;
  int                    drop_n;

  assign ts_d = en_i ? ts_q + 1'b1 : ts_q;

  generate
    for (genvar gi = 0; gi < CH_N; gi++) begin : g_hold
      logic          vld_q;
      logic [DW-1:0] data_q;
      logic [TSW-1:0] ts_cap_q;

      // A granted register frees its slot this cycle, so it may reload at once.
      assign cap[gi]  = en_i & ch_vld_i[gi] & (~vld_q | gnt[gi]);
      assign drop[gi] = en_i & ch_vld_i[gi] & vld_q & ~gnt[gi];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          vld_q    <= 1'b0;
          data_q   <= '0;
          ts_cap_q <= '0;
        end else if (cap[gi]) begin
          vld_q    <= 1'b1;
          data_q   <= ch_data_i[gi*DW +: DW];
          ts_cap_q <= ts_q;
        end else if (gnt[gi]) begin
          vld_q    <= 1'b0;
        end
      end

      assign hold_vld[gi]              = vld_q;
      assign hold_data[gi*DW +: DW]    = data_q;
      assign hold_ts[gi*TSW +: TSW]    = ts_cap_q;
    end
  endgenerate

  assign pop     = rd_vld_o & rd_rdy_i;
  assign can_acc = (level_q != LW'(DEPTH)) | pop;

  dvv_rr_arb #(.N(CH_N)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (hold_vld),
    .en_i      (can_acc),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign push     = |gnt;
  assign wr_entry = {gnt_idx, hold_ts[int'(gnt_idx)*TSW +: TSW], hold_data[int'(gnt_idx)*DW +: DW]};

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Head is read straight from memory; gating keeps outputs quiet when empty.
  assign head      = mem[rd_ptr_q];
  assign rd_vld_o  = (level_q != '0);
  assign rd_data_o = rd_vld_o ? head[DW-1:0]        : '0;
  assign rd_ts_o   = rd_vld_o ? head[DW +: TSW]     : '0;
  assign rd_ch_o   = rd_vld_o ? head[DW+TSW +: CW]  : '0;
  assign level_o   = level_q;

  always_comb begin
    drop_n = 0;
    for (int i = 0; i < CH_N; i++) drop_n = drop_n + int'(drop[i]);
    drop_sum   = {1'b0, drop_cnt_q} + (DROP_CNT_W+1)'(drop_n);
    drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    if (clr_i) drop_cnt_d = '0;
    // A drop coinciding with clear still leaves its flag behind.
    ovf_d = (clr_i ? '0 : ovf_q) | drop;
  end

  assign drop_cnt_o = drop_cnt_q;
  assign ovf_mask_o = ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= '0;
    end else begin
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule
